pulse_meter: RTL and testbench

//  Multi-channel pulse-width timer, the parametrised successor of the single-channel timer.

---
 rtl/pulse_meter_pkg.sv | 24 ++
 rtl/pulse_meter_chan.sv | 106 ++++++++++
 rtl/pulse_meter.sv | 128 ++++++++++++
 tb/tb_pulse_meter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_meter_pkg.sv
// ============================================================================
// Module      : pulse_meter_pkg
// Description : Shared channel FSM encoding and channel-index width helper
//               for the multi-channel pulse-width meter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_meter_pkg;

    typedef enum logic [1:0] {
        ST_DISARM = 2'd0,
        ST_IDLE   = 2'd1,
        ST_COUNT  = 2'd2
    } chan_state_t;

    // A single channel still needs a one-bit index on the output stream.
    function automatic int chw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : pulse_meter_pkg

`default_nettype wire

// File: rtl/pulse_meter_chan.sv
// ============================================================================
// Module      : pulse_meter_chan
// Description : One pulse-width channel: arm/idle/count FSM, saturating
//               length counter and a single-entry record buffer with drop flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_meter_chan
    import pulse_meter_pkg::*;
#(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             act,
    input  logic             en,
    input  logic             take,
    output logic             pend,
    output logic [WIDTH-1:0] rec_data,
    output logic             rec_ovf,
    output logic             rec_drop
);

    localparam logic [WIDTH-1:0] C_CNT_MAX = '1;

    chan_state_t      r_state;
    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;
    logic [WIDTH-1:0] r_rec_data;
    logic             r_rec_ovf;
    logic             r_pend;
    logic             r_drop;
    logic             w_end;

    // A disable on the same edge as the falling edge discards the pulse.
    assign w_end = (r_state == ST_COUNT) && en && !act;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_DISARM;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_rec_data <= '0;
            r_rec_ovf  <= 1'b0;
            r_pend     <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            if (!en) begin
                r_state <= ST_DISARM;
                r_cnt   <= '0;
                r_ovf   <= 1'b0;
            end else begin
                case (r_state)
                    ST_DISARM: begin
                        if (!act) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_IDLE: begin
                        if (act) begin
                            r_cnt   <= WIDTH'(1);
                            r_ovf   <= 1'b0;
                            r_state <= ST_COUNT;
                        end
                    end
                    ST_COUNT: begin
                        if (act) begin
                            if (r_cnt == C_CNT_MAX) begin
                                r_ovf <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + WIDTH'(1);
                            end
                        end else begin
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_DISARM;
                        r_cnt   <= '0;
                    end
                endcase
            end

            // When the old record leaves on the same edge, nothing is lost.
            if (w_end) begin
                r_rec_data <= r_cnt;
                r_rec_ovf  <= r_ovf;
                r_pend     <= 1'b1;
                r_drop     <= r_pend && !take;
            end else if (take) begin
                r_pend <= 1'b0;
                r_drop <= 1'b0;
            end
        end
    end

    assign pend     = r_pend;
    assign rec_data = r_rec_data;
    assign rec_ovf  = r_rec_ovf;
    assign rec_drop = r_drop;

endmodule : pulse_meter_chan

`default_nettype wire

// File: rtl/pulse_meter.sv
// ============================================================================
// Module      : pulse_meter
// Description : Multi-channel pulse-width timer with round-robin draining of
//               per-channel records onto a registered valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter  int WIDTH    = 11,
    parameter  int CHANNELS = 4,
    localparam int CHW      = chw_of(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    input  logic [CHANNELS-1:0] pol,
    input  logic [CHANNELS-1:0] en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CHW-1:0]      out_chan,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_ovf,
    output logic                out_drop
);

    logic [CHANNELS-1:0] w_act;
    logic [CHANNELS-1:0] w_pend;
    logic [CHANNELS-1:0] w_rec_ovf;
    logic [CHANNELS-1:0] w_rec_drop;
    logic [CHANNELS-1:0] w_take;
    logic [WIDTH-1:0]    w_rec_data [CHANNELS];

    logic                r_out_valid;
    logic [CHW-1:0]      r_out_chan;
    logic [WIDTH-1:0]    r_out_data;
    logic                r_out_ovf;
    logic                r_out_drop;
    logic [CHW-1:0]      r_rr_ptr;

    logic                w_load;
    logic                w_found;
    logic [CHW-1:0]      w_grant;
    logic [WIDTH-1:0]    w_sel_data;
    logic                w_sel_ovf;
    logic                w_sel_drop;
    int                  v_dist;
    int                  v_best;

    assign w_act = in ^ pol;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        pulse_meter_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .act      (w_act[g]),
            .en       (en[g]),
            .take     (w_take[g]),
            .pend     (w_pend[g]),
            .rec_data (w_rec_data[g]),
            .rec_ovf  (w_rec_ovf[g]),
            .rec_drop (w_rec_drop[g])
        );
    end

    // Rotated priority: the pending channel closest after rr_ptr wins.
    always_comb begin
        w_found    = 1'b0;
        w_grant    = '0;
        w_sel_data = '0;
        w_sel_ovf  = 1'b0;
        w_sel_drop = 1'b0;
        v_best     = CHANNELS;
        v_dist     = 0;
        for (int j = 0; j < CHANNELS; j++) begin
            v_dist = j - int'(r_rr_ptr);
            if (v_dist < 0) begin
                v_dist = v_dist + CHANNELS;
            end
            if (w_pend[j] && (v_dist < v_best)) begin
                v_best     = v_dist;
                w_found    = 1'b1;
                w_grant    = CHW'(j);
                w_sel_data = w_rec_data[j];
                w_sel_ovf  = w_rec_ovf[j];
                w_sel_drop = w_rec_drop[j];
            end
        end
    end

    assign w_load = !r_out_valid || out_ready;
    assign w_take = (w_load && w_found) ? (CHANNELS'(1) << w_grant) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_chan  <= '0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
            r_out_drop  <= 1'b0;
            r_rr_ptr    <= '0;
        end else if (w_load) begin
            if (w_found) begin
                r_out_valid <= 1'b1;
                r_out_chan  <= w_grant;
                r_out_data  <= w_sel_data;
                r_out_ovf   <= w_sel_ovf;
                r_out_drop  <= w_sel_drop;
                r_rr_ptr    <= (w_grant == CHW'(CHANNELS - 1)) ? '0 : w_grant + CHW'(1);
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_chan  = r_out_chan;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;
    assign out_drop  = r_out_drop;

endmodule : pulse_meter

`default_nettype wire

// File: tb/tb_pulse_meter.sv
// ============================================================================
// Module      : tb_pulse_meter
// Description : Scoreboard bench for pulse_meter (WIDTH=4, CHANNELS=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_meter;

    localparam int WIDTH    = 4;
    localparam int CHANNELS = 4;

    typedef struct packed {
        logic [1:0] chan;
        logic [3:0] data;
        logic       ovf;
        logic       drop;
    } rec_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [CHANNELS-1:0] in;
    logic [CHANNELS-1:0] pol;
    logic [CHANNELS-1:0] en;
    logic                out_valid;
    logic                out_ready;
    logic [1:0]          out_chan;
    logic [WIDTH-1:0]    out_data;
    logic                out_ovf;
    logic                out_drop;

    rec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    pulse_meter #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .pol       (pol),
        .en        (en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_drop  (out_drop)
    );

    always #5 clk = ~clk;

    // Every presented record must match the scoreboard head, stalled or not.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_record: got chan=%0d data=%0d ovf=%0d drop=%0d, required no record",
                         out_chan, out_data, out_ovf, out_drop);
            end else begin
                if ({out_chan, out_data, out_ovf, out_drop} != exp_q[0]) begin
                    bad++;
                    $display("FAIL record: got chan=%0d data=%0d ovf=%0d drop=%0d, required chan=%0d data=%0d ovf=%0d drop=%0d",
                             out_chan, out_data, out_ovf, out_drop,
                             exp_q[0].chan, exp_q[0].data, exp_q[0].ovf, exp_q[0].drop);
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_rec(input int ch, input int data, input int ovf, input int drop);
        rec_t r;
        r.chan = 2'(ch);
        r.data = 4'(data);
        r.ovf  = 1'(ovf);
        r.drop = 1'(drop);
        exp_q.push_back(r);
    endtask

    task automatic pulse(input int ch, input int n);
        in[ch] = ~pol[ch];
        step(n);
        in[ch] = pol[ch];
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 100;
        while (exp_q.size() != 0 && budget > 0) begin
            step(1);
            budget--;
        end
        check(name, exp_q.size(), 0);
        step(3);
        check({name, "_idle"}, int'(out_valid), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_chan"},  int'(out_chan),  0);
        check({tag, "_data"},  int'(out_data),  0);
        check({tag, "_ovf"},   int'(out_ovf),   0);
        check({tag, "_drop"},  int'(out_drop),  0);
    endtask

    initial begin
        rst       = 1'b1;
        in        = '0;
        pol       = '0;
        en        = '0;
        out_ready = 1'b1;
        step(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        step(1);

        // Single 5-cycle high pulse on channel 0.
        en[0] = 1'b1;
        step(2);
        expect_rec(0, 5, 0, 0);
        pulse(0, 5);
        drain("t1_basic");

        // Saturation at 15 with overflow, then a normal short pulse.
        en[1] = 1'b1;
        step(2);
        expect_rec(1, 15, 1, 0);
        pulse(1, 20);
        step(2);
        expect_rec(1, 3, 0, 0);
        pulse(1, 3);
        drain("t2_saturate");

        // Inverted polarity on channel 2: low stretches are measured.
        pol[2] = 1'b1;
        in[2]  = 1'b1;
        step(1);
        en[2]  = 1'b1;
        step(2);
        expect_rec(2, 7, 0, 0);
        pulse(2, 7);
        drain("t3_pol");
        step(10);
        check("t3_high_no_record", int'(out_valid), 0);

        // Channels 0 and 2 end on the same edge; rr_ptr is 3 so ch0 first.
        in[2] = 1'b0;
        step(5);
        in[0] = 1'b1;
        step(4);
        expect_rec(0, 4, 0, 0);
        expect_rec(2, 9, 0, 0);
        in[0] = 1'b0;
        in[2] = 1'b1;
        drain("t4_simul");

        // Stalled output: ch0 record held, ch1 overwritten with drop set.
        out_ready = 1'b0;
        expect_rec(0, 2, 0, 0);
        pulse(0, 2);
        step(3);
        check("t5_stall_valid", int'(out_valid), 1);
        expect_rec(1, 6, 0, 1);
        pulse(1, 3);
        step(2);
        pulse(1, 6);
        step(4);
        check("t5_still_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        drain("t5_drop");

        // rr_ptr is 2 after the ch1 grant: ch3 must beat ch0.
        en[3] = 1'b1;
        step(2);
        in[3] = 1'b1;
        step(1);
        in[0] = 1'b1;
        step(2);
        expect_rec(3, 3, 0, 0);
        expect_rec(0, 2, 0, 0);
        in[0] = 1'b0;
        in[3] = 1'b0;
        drain("t7_rr");

        // Pulse spanning reset release and an enable toggle is never measured.
        in[3] = 1'b1;
        step(2);
        rst = 1'b1;
        step(2);
        check_reset_outputs("t6_reset");
        exp_q.delete();
        rst = 1'b0;
        step(3);
        en[3] = 1'b0;
        step(2);
        en[3] = 1'b1;
        step(3);
        check("t6_no_partial", int'(out_valid), 0);
        in[3] = 1'b0;
        step(2);
        expect_rec(3, 2, 0, 0);
        pulse(3, 2);
        drain("t6_rearm");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pulse_meter

`default_nettype wire
